// File: rtl/seg7_to_bcd_scanner_pkg.sv
// Shared segment-code constants, digit payload type and scanner state encoding
// for the 7-segment receive path.
package seg7_to_bcd_scanner_pkg;

    localparam int unsigned SEG_W = 7;
    localparam int unsigned BCD_W = 4;

    // Segment codes in bit order {a,b,c,d,e,f,g} = {S6..S0}
    localparam logic [SEG_W-1:0] SEG_0     = 7'b1111110;
    localparam logic [SEG_W-1:0] SEG_1     = 7'b0110000;
    localparam logic [SEG_W-1:0] SEG_2     = 7'b1101101;
    localparam logic [SEG_W-1:0] SEG_3     = 7'b1111001;
    localparam logic [SEG_W-1:0] SEG_4     = 7'b0110011;
    localparam logic [SEG_W-1:0] SEG_5     = 7'b1011011;
    localparam logic [SEG_W-1:0] SEG_6     = 7'b1011111;
    localparam logic [SEG_W-1:0] SEG_7     = 7'b1110010;
    localparam logic [SEG_W-1:0] SEG_8     = 7'b1111111;
    localparam logic [SEG_W-1:0] SEG_9     = 7'b1111011;
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'b0000000;

    localparam logic [BCD_W-1:0] BCD_BLANK = 4'hF;
    localparam logic [BCD_W-1:0] BCD_ERR   = 4'hE;

    typedef struct packed {
        logic [BCD_W-1:0] bcd;
        logic             err;
        logic             blank;
    } digit_t;

    localparam digit_t DIGIT_RST = '{bcd: BCD_BLANK, err: 1'b0, blank: 1'b1};

    typedef enum logic [1:0] {
        ST_WAIT   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_HOLD   = 2'd2
    } scan_state_e;

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational 7-segment pattern to BCD decoder; blank and illegal patterns
// are reported through their own flags.
module seg7_pattern_decode
    import seg7_to_bcd_scanner_pkg::*;
(
    input  logic [SEG_W-1:0] pattern_i,
    output logic [BCD_W-1:0] bcd_c_o,
    output logic             err_c_o,
    output logic             blank_c_o
);

    always_comb begin
        bcd_c_o = BCD_ERR;
        case (pattern_i)
            SEG_0:     bcd_c_o = 4'd0;
            SEG_1:     bcd_c_o = 4'd1;
            SEG_2:     bcd_c_o = 4'd2;
            SEG_3:     bcd_c_o = 4'd3;
            SEG_4:     bcd_c_o = 4'd4;
            SEG_5:     bcd_c_o = 4'd5;
            SEG_6:     bcd_c_o = 4'd6;
            SEG_7:     bcd_c_o = 4'd7;
            SEG_8:     bcd_c_o = 4'd8;
            SEG_9:     bcd_c_o = 4'd9;
            SEG_BLANK: bcd_c_o = BCD_BLANK;
            default:   bcd_c_o = BCD_ERR;
        endcase
        // Legal digits never decode to E or F, so the flags follow from the code
        err_c_o   = (bcd_c_o == BCD_ERR);
        blank_c_o = (bcd_c_o == BCD_BLANK);
    end

endmodule

// File: rtl/seg7_to_bcd_scanner.sv
// Samples a multiplexed 7-segment bus, waits for each digit to settle, and
// publishes a coherent multi-digit BCD frame once every position was captured.
module seg7_to_bcd_scanner
    import seg7_to_bcd_scanner_pkg::*;
#(
    parameter int unsigned NDIG       = 4,
    parameter int unsigned STABLE_CYC = 3
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  S6,
    input  logic                  S5,
    input  logic                  S4,
    input  logic                  S3,
    input  logic                  S2,
    input  logic                  S1,
    input  logic                  S0,
    input  logic [NDIG-1:0]       DIG_SEL,
    output logic [BCD_W*NDIG-1:0] BCD,
    output logic [NDIG-1:0]       DIG_ERR,
    output logic [NDIG-1:0]       DIG_BLANK,
    output logic                  FRAME_VALID,
    output logic                  SEL_ERR
);

    localparam int unsigned CNT_W = 4;
    localparam int unsigned RUN_W = CNT_W + 1;

    logic [SEG_W-1:0] smp_seg_q, prv_seg_q;
    logic [NDIG-1:0]  smp_sel_q, prv_sel_q;
    scan_state_e      state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [NDIG-1:0]  seen_q;
    digit_t [NDIG-1:0] shadow_q;
    digit_t [NDIG-1:0] frame_q;
    logic             fv_q;
    logic             sel_err_q;

    logic             sel_valid_d;
    logic             sel_bad_d;
    logic             sel_changed_d;
    logic             changed_d;
    logic [RUN_W-1:0] run_d;
    logic             capture_d;
    logic             commit_d;
    logic [NDIG-1:0]  seen_d;
    digit_t           dec_d;

    seg7_pattern_decode u_decode (
        .pattern_i (smp_seg_q),
        .bcd_c_o   (dec_d.bcd),
        .err_c_o   (dec_d.err),
        .blank_c_o (dec_d.blank)
    );

    // Run length counts the current sample, so a fresh value starts at 1
    always_comb begin
        sel_valid_d   = (smp_sel_q != '0) && ((smp_sel_q & (smp_sel_q - NDIG'(1))) == '0);
        sel_bad_d     = (smp_sel_q != '0) && !sel_valid_d;
        sel_changed_d = (smp_sel_q != prv_sel_q);
        changed_d     = (smp_seg_q != prv_seg_q) || sel_changed_d;
        run_d         = changed_d ? RUN_W'(1) : RUN_W'(cnt_q) + RUN_W'(1);
        capture_d     = sel_valid_d && !((state_q == ST_HOLD) && !changed_d)
                        && (run_d >= RUN_W'(STABLE_CYC));
        commit_d      = &seen_q;
        // Clear on commit first so a same-edge capture counts toward the next frame
        seen_d        = (commit_d ? '0 : seen_q) | (capture_d ? smp_sel_q : '0);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            smp_seg_q <= '0;
            smp_sel_q <= '0;
            prv_seg_q <= '0;
            prv_sel_q <= '0;
            state_q   <= ST_WAIT;
            cnt_q     <= '0;
            seen_q    <= '0;
            shadow_q  <= '0;
            fv_q      <= 1'b0;
            sel_err_q <= 1'b0;
            for (int i = 0; i < NDIG; i++) begin
                frame_q[i] <= DIGIT_RST;
            end
        end else begin
            smp_seg_q <= {S6, S5, S4, S3, S2, S1, S0};
            smp_sel_q <= DIG_SEL;
            prv_seg_q <= smp_seg_q;
            prv_sel_q <= smp_sel_q;

            sel_err_q <= sel_bad_d && sel_changed_d;
            fv_q      <= commit_d;
            seen_q    <= seen_d;
            if (commit_d) begin
                frame_q <= shadow_q;
            end
            for (int i = 0; i < NDIG; i++) begin
                if (capture_d && smp_sel_q[i]) begin
                    shadow_q[i] <= dec_d;
                end
            end

            if (!sel_valid_d) begin
                state_q <= ST_WAIT;
                cnt_q   <= '0;
            end else if (capture_d) begin
                state_q <= ST_HOLD;
                cnt_q   <= '0;
            end else if ((state_q == ST_HOLD) && !changed_d) begin
                state_q <= ST_HOLD;
                cnt_q   <= '0;
            end else begin
                state_q <= ST_SETTLE;
                cnt_q   <= CNT_W'(run_d);
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NDIG; i++) begin
            BCD[BCD_W*i +: BCD_W] = frame_q[i].bcd;
            DIG_ERR[i]            = frame_q[i].err;
            DIG_BLANK[i]          = frame_q[i].blank;
        end
    end

    assign FRAME_VALID = fv_q;
    assign SEL_ERR     = sel_err_q;

endmodule

// File: tb/tb_seg7_to_bcd_scanner.sv
// Directed bench for seg7_to_bcd_scanner (NDIG=4, STABLE_CYC=3) with
// hand-computed expected frames.
module tb_seg7_to_bcd_scanner;
    import seg7_to_bcd_scanner_pkg::*;

    localparam int unsigned NDIG = 4;

    logic            CLK = 1'b0;
    logic            RST = 1'b1;
    logic [6:0]      seg = '0;
    logic [NDIG-1:0] sel = '0;
    logic [4*NDIG-1:0] BCD;
    logic [NDIG-1:0] DIG_ERR;
    logic [NDIG-1:0] DIG_BLANK;
    logic            FRAME_VALID;
    logic            SEL_ERR;

    int n_checks = 0;
    int n_errors = 0;
    int fv_cnt   = 0;
    int se_cnt   = 0;
    int f0;
    int s0;

    always #5 CLK = ~CLK;

    seg7_to_bcd_scanner #(.NDIG(NDIG), .STABLE_CYC(3)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .S6          (seg[6]),
        .S5          (seg[5]),
        .S4          (seg[4]),
        .S3          (seg[3]),
        .S2          (seg[2]),
        .S1          (seg[1]),
        .S0          (seg[0]),
        .DIG_SEL     (sel),
        .BCD         (BCD),
        .DIG_ERR     (DIG_ERR),
        .DIG_BLANK   (DIG_BLANK),
        .FRAME_VALID (FRAME_VALID),
        .SEL_ERR     (SEL_ERR)
    );

    // Pulse counters sampled away from the active edge
    always @(negedge CLK) begin
        if (FRAME_VALID) fv_cnt++;
        if (SEL_ERR) se_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic hold(input logic [NDIG-1:0] s, input logic [6:0] p, input int n);
        sel = s;
        seg = p;
        repeat (n) @(negedge CLK);
    endtask

    task automatic frame(input logic [6:0] d3, input logic [6:0] d2,
                         input logic [6:0] d1, input logic [6:0] d0);
        hold(4'b1000, d3, 5);
        hold(4'b0100, d2, 5);
        hold(4'b0010, d1, 5);
        hold(4'b0001, d0, 5);
        hold(4'b0000, SEG_BLANK, 4);
    endtask

    initial begin
        repeat (3) @(negedge CLK);
        RST = 1'b0;
        repeat (20) @(negedge CLK);
        check("rst_bcd",   32'(BCD),       32'hFFFF);
        check("rst_blank", 32'(DIG_BLANK), 32'hF);
        check("rst_err",   32'(DIG_ERR),   32'h0);
        check("rst_no_fv", 32'(fv_cnt),    32'd0);
        check("rst_no_se", 32'(se_cnt),    32'd0);

        // Basic frame 1,9,8,4
        f0 = fv_cnt;
        frame(SEG_1, SEG_9, SEG_8, SEG_4);
        check("f1984_fv",    32'(fv_cnt - f0), 32'd1);
        check("f1984_bcd",   32'(BCD),         32'h1984);
        check("f1984_err",   32'(DIG_ERR),     32'h0);
        check("f1984_blank", 32'(DIG_BLANK),   32'h0);

        // Illegal and blank patterns
        f0 = fv_cnt;
        frame(SEG_5, 7'b0000001, SEG_7, SEG_BLANK);
        check("f5e7f_fv",    32'(fv_cnt - f0), 32'd1);
        check("f5e7f_bcd",   32'(BCD),         32'h5E7F);
        check("f5e7f_err",   32'(DIG_ERR),     32'h4);
        check("f5e7f_blank", 32'(DIG_BLANK),   32'h1);

        // Digit 1 held too briefly, then held exactly STABLE_CYC
        f0 = fv_cnt;
        hold(4'b1000, SEG_1, 5);
        hold(4'b0100, SEG_9, 5);
        hold(4'b0010, SEG_8, 2);
        hold(4'b0001, SEG_4, 5);
        hold(4'b0000, SEG_BLANK, 6);
        check("short_no_fv", 32'(fv_cnt - f0), 32'd0);
        check("short_hold",  32'(BCD),         32'h5E7F);
        hold(4'b0010, SEG_8, 3);
        hold(4'b0000, SEG_BLANK, 4);
        check("min_fv",  32'(fv_cnt - f0), 32'd1);
        check("min_bcd", 32'(BCD),         32'h1984);

        // Non-one-hot select: single SEL_ERR pulse, no capture
        f0 = fv_cnt;
        s0 = se_cnt;
        hold(4'b1000, SEG_3, 5);
        hold(4'b0100, SEG_6, 5);
        hold(4'b0010, SEG_0, 5);
        hold(4'b0110, SEG_2, 4);
        hold(4'b0000, SEG_BLANK, 4);
        check("selerr_once",  32'(se_cnt - s0), 32'd1);
        check("selerr_no_fv", 32'(fv_cnt - f0), 32'd0);
        hold(4'b0001, SEG_2, 5);
        hold(4'b0000, SEG_BLANK, 4);
        check("selerr_resume_fv",  32'(fv_cnt - f0), 32'd1);
        check("selerr_resume_bcd", 32'(BCD),         32'h3602);
        check("selerr_still_once", 32'(se_cnt - s0), 32'd1);

        // Reset mid-frame discards partial state
        hold(4'b1000, SEG_7, 5);
        hold(4'b0100, SEG_2, 5);
        hold(4'b0010, SEG_5, 5);
        sel = '0;
        seg = SEG_BLANK;
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        check("midrst_bcd",   32'(BCD),         32'hFFFF);
        check("midrst_err",   32'(DIG_ERR),     32'h0);
        check("midrst_blank", 32'(DIG_BLANK),   32'hF);
        check("midrst_fv",    32'(FRAME_VALID), 32'h0);
        f0 = fv_cnt;
        hold(4'b0001, SEG_6, 5);
        hold(4'b0000, SEG_BLANK, 6);
        check("midrst_no_fv", 32'(fv_cnt - f0), 32'd0);
        check("midrst_keep",  32'(BCD),         32'hFFFF);
        frame(SEG_7, SEG_2, SEG_5, SEG_6);
        check("replay_fv",  32'(fv_cnt - f0), 32'd1);
        check("replay_bcd", 32'(BCD),         32'h7256);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
